fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_types_pkg.sv | 19 +
 rtl/ifid_latch.sv | 39 +++
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared word type, fetch FSM states and PC step helper
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      HELD   = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

   localparam word_t INSTR_BYTES = 32'd4;

   // Sequential PC step; wraps modulo 2^32 with no overflow indication.
   function automatic word_t next_pc(input word_t pc);
      return pc + INSTR_BYTES;
   endfunction

endpackage

// File: rtl/ifid_latch.sv
// rtl/ifid_latch.sv - IF/ID pipeline register with load, hold and bubble controls
module ifid_latch
   import cpu_types_pkg::*;
(
   input  logic        CLK,
   input  logic        nRST,
   input  logic        load,
   input  logic        bubble,
   input  logic [31:0] instr_in,
   input  logic [31:0] npc_in,
   output logic [31:0] instr,
   output logic [31:0] npc,
   output logic        valid
);

   word_t instr_q;
   word_t npc_q;
   logic  valid_q;

   // A bubble only clears valid; the data fields keep their last contents.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         instr_q <= '0;
         npc_q   <= '0;
         valid_q <= 1'b0;
      end else if (bubble) begin
         valid_q <= 1'b0;
      end else if (load) begin
         instr_q <= instr_in;
         npc_q   <= npc_in;
         valid_q <= 1'b1;
      end
   end

   assign instr = instr_q;
   assign npc   = npc_q;
   assign valid = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, one-entry stash, FSM, delivery counter
module fetch_unit
   import cpu_types_pkg::*;
#(
   parameter logic [31:0] PC_INIT = 32'h00000000
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ihit,
   input  logic [31:0] imemload,
   input  logic        stall,
   input  logic        dwait,
   input  logic        redirect_en,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic        imemREN,
   output logic [31:0] imemaddr,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_npc,
   output logic        ifid_valid,
   output logic        halted,
   output logic [31:0] fetch_count
);

   fetch_state_t state, next_state;
   word_t        pc, pc_next;
   word_t        stash, stash_next;
   word_t        count;
   word_t        ifid_data;
   logic         ifid_load;
   logic         ifid_bubble;
   logic         count_inc;
   logic         freeze;

   assign freeze = stall | dwait;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= FETCH;
         pc    <= PC_INIT;
         stash <= '0;
         count <= '0;
      end else begin
         state <= next_state;
         pc    <= pc_next;
         stash <= stash_next;
         if (count_inc)
            count <= count + 32'd1;
      end
   end

   // Priority per edge: halt, then redirect (blocked by dwait), then freeze, then ihit.
   always_comb begin
      next_state  = state;
      pc_next     = pc;
      stash_next  = stash;
      ifid_data   = imemload;
      ifid_load   = 1'b0;
      ifid_bubble = 1'b0;
      count_inc   = 1'b0;
      case (state)
         HALTED: begin
         end
         default: begin
            if (halt) begin
               next_state  = HALTED;
               ifid_bubble = 1'b1;
            end else if (redirect_en && !dwait) begin
               pc_next     = redirect_pc;
               stash_next  = '0;
               ifid_bubble = 1'b1;
               next_state  = FETCH;
            end else if (freeze) begin
               if (state == FETCH && ihit) begin
                  stash_next = imemload;
                  next_state = HELD;
               end
            end else if (state == HELD) begin
               ifid_data  = stash;
               ifid_load  = 1'b1;
               pc_next    = next_pc(pc);
               count_inc  = 1'b1;
               next_state = FETCH;
            end else if (ihit) begin
               ifid_load = 1'b1;
               pc_next   = next_pc(pc);
               count_inc = 1'b1;
            end else begin
               ifid_bubble = 1'b1;
            end
         end
      endcase
   end

   ifid_latch u_ifid (
      .CLK      (CLK),
      .nRST     (nRST),
      .load     (ifid_load),
      .bubble   (ifid_bubble),
      .instr_in (ifid_data),
      .npc_in   (next_pc(pc)),
      .instr    (ifid_instr),
      .npc      (ifid_npc),
      .valid    (ifid_valid)
   );

   assign imemREN     = (state == FETCH);
   assign halted      = (state == HALTED);
   assign imemaddr    = pc;
   assign fetch_count = count;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed vector table, corner sequences and randomized model check of fetch_unit
module tb_fetch_unit;

   localparam logic [31:0] PC_INIT = 32'h00000000;

   logic        CLK;
   logic        nRST;
   logic        ihit;
   logic [31:0] imemload;
   logic        stall;
   logic        dwait;
   logic        redirect_en;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_npc;
   logic        ifid_valid;
   logic        halted;
   logic [31:0] fetch_count;

   int n_cmp = 0;
   int n_mis = 0;

   fetch_unit #(.PC_INIT(PC_INIT)) dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .ihit        (ihit),
      .imemload    (imemload),
      .stall       (stall),
      .dwait       (dwait),
      .redirect_en (redirect_en),
      .redirect_pc (redirect_pc),
      .halt        (halt),
      .imemREN     (imemREN),
      .imemaddr    (imemaddr),
      .ifid_instr  (ifid_instr),
      .ifid_npc    (ifid_npc),
      .ifid_valid  (ifid_valid),
      .halted      (halted),
      .fetch_count (fetch_count)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   typedef struct {
      logic        ih;
      logic [31:0] ld;
      logic        st;
      logic        dw;
      logic        rd;
      logic [31:0] rp;
      logic        hl;
      logic [31:0] e_addr;
      logic        e_ren;
      logic        e_halted;
      logic        e_valid;
      logic [31:0] e_instr;
      logic [31:0] e_npc;
      logic [31:0] e_cnt;
   } vec_t;

   vec_t vt[$];

   // Reference model state: the stash is a queue of at most one word, a
   // non-empty stash is what suppresses the read request.
   logic [31:0] m_pc, m_instr, m_npc, m_cnt;
   logic        m_valid, m_halted;
   logic [31:0] m_stash[$];

   function automatic vec_t mk(input logic ih, input logic [31:0] ld, input logic st, input logic dw,
                               input logic rd, input logic [31:0] rp, input logic hl,
                               input logic [31:0] ea, input logic er, input logic eh, input logic ev,
                               input logic [31:0] ei, input logic [31:0] en, input logic [31:0] ec);
      vec_t v;
      v.ih = ih; v.ld = ld; v.st = st; v.dw = dw; v.rd = rd; v.rp = rp; v.hl = hl;
      v.e_addr = ea; v.e_ren = er; v.e_halted = eh; v.e_valid = ev;
      v.e_instr = ei; v.e_npc = en; v.e_cnt = ec;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [31:0] ea, input logic er, input logic eh,
                          input logic ev, input logic [31:0] ei, input logic [31:0] en,
                          input logic [31:0] ec);
      chk({tag, ".imemaddr"}, imemaddr, ea);
      chk({tag, ".imemREN"}, {31'd0, imemREN}, {31'd0, er});
      chk({tag, ".halted"}, {31'd0, halted}, {31'd0, eh});
      chk({tag, ".ifid_valid"}, {31'd0, ifid_valid}, {31'd0, ev});
      chk({tag, ".ifid_instr"}, ifid_instr, ei);
      chk({tag, ".ifid_npc"}, ifid_npc, en);
      chk({tag, ".fetch_count"}, fetch_count, ec);
   endtask

   task automatic drive(input logic ih, input logic [31:0] ld, input logic st, input logic dw,
                        input logic rd, input logic [31:0] rp, input logic hl);
      ihit = ih; imemload = ld; stall = st; dwait = dw;
      redirect_en = rd; redirect_pc = rp; halt = hl;
      @(posedge CLK);
      @(negedge CLK);
   endtask

   // Asynchronous reset asserted between edges; outputs are checked before any clock edge.
   task automatic do_reset(input string tag);
      ihit = 0; imemload = '0; stall = 0; dwait = 0; redirect_en = 0; redirect_pc = '0; halt = 0;
      nRST = 1'b0;
      #1;
      chk_all(tag, PC_INIT, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
      @(negedge CLK);
      nRST = 1'b1;
   endtask

   task automatic model_reset();
      m_pc = PC_INIT; m_instr = '0; m_npc = '0; m_cnt = '0;
      m_valid = 1'b0; m_halted = 1'b0;
      m_stash.delete();
   endtask

   task automatic model_step(input logic ih, input logic [31:0] ld, input logic st, input logic dw,
                             input logic rd, input logic [31:0] rp, input logic hl);
      if (m_halted) begin
      end else if (hl) begin
         m_halted = 1'b1;
         m_valid  = 1'b0;
      end else if (rd && !dw) begin
         m_pc    = rp;
         m_valid = 1'b0;
         m_stash.delete();
      end else if (st || dw) begin
         if (m_stash.size() == 0 && ih)
            m_stash.push_back(ld);
      end else if (m_stash.size() != 0) begin
         m_instr = m_stash.pop_front();
         m_pc    = m_pc + 32'd4;
         m_npc   = m_pc;
         m_valid = 1'b1;
         m_cnt   = m_cnt + 32'd1;
      end else if (ih) begin
         m_instr = ld;
         m_pc    = m_pc + 32'd4;
         m_npc   = m_pc;
         m_valid = 1'b1;
         m_cnt   = m_cnt + 32'd1;
      end else begin
         m_valid = 1'b0;
      end
   endtask

   initial begin
      logic [31:0] ld, rp;
      logic        ih, st, dw, rd, hl;

      ihit = 0; imemload = '0; stall = 0; dwait = 0;
      redirect_en = 0; redirect_pc = '0; halt = 0;
      nRST = 1'b1;
      #1;
      do_reset("reset0");

      vt.push_back(mk(1, 32'hA000_0001, 0, 0, 0, 0, 0, 32'h04, 1, 0, 1, 32'hA000_0001, 32'h04, 1));
      vt.push_back(mk(1, 32'hB000_0002, 0, 0, 0, 0, 0, 32'h08, 1, 0, 1, 32'hB000_0002, 32'h08, 2));
      vt.push_back(mk(1, 32'hC000_0003, 0, 0, 0, 0, 0, 32'h0C, 1, 0, 1, 32'hC000_0003, 32'h0C, 3));
      vt.push_back(mk(1, 32'hD000_0004, 0, 0, 0, 0, 0, 32'h10, 1, 0, 1, 32'hD000_0004, 32'h10, 4));
      vt.push_back(mk(0, 32'h0,         0, 0, 0, 0, 0, 32'h10, 1, 0, 0, 32'hD000_0004, 32'h10, 4));
      vt.push_back(mk(1, 32'hE000_0005, 1, 0, 0, 0, 0, 32'h10, 0, 0, 0, 32'hD000_0004, 32'h10, 4));
      vt.push_back(mk(1, 32'hF000_0006, 1, 0, 0, 0, 0, 32'h10, 0, 0, 0, 32'hD000_0004, 32'h10, 4));
      vt.push_back(mk(0, 32'h0,         0, 0, 0, 0, 0, 32'h14, 1, 0, 1, 32'hE000_0005, 32'h14, 5));
      vt.push_back(mk(1, 32'hF000_0006, 1, 0, 0, 0, 0, 32'h14, 0, 0, 1, 32'hE000_0005, 32'h14, 5));
      vt.push_back(mk(0, 32'h0, 1, 0, 1, 32'h200, 0, 32'h200, 1, 0, 0, 32'hE000_0005, 32'h14, 5));
      vt.push_back(mk(0, 32'h0, 0, 1, 1, 32'h080, 0, 32'h200, 1, 0, 0, 32'hE000_0005, 32'h14, 5));
      vt.push_back(mk(0, 32'h0, 0, 0, 1, 32'h080, 0, 32'h080, 1, 0, 0, 32'hE000_0005, 32'h14, 5));
      vt.push_back(mk(1, 32'h1234_0007, 0, 0, 0, 0, 0, 32'h84, 1, 0, 1, 32'h1234_0007, 32'h84, 6));
      vt.push_back(mk(1, 32'h9999_0008, 0, 0, 1, 32'h300, 1, 32'h84, 0, 1, 0, 32'h1234_0007, 32'h84, 6));
      vt.push_back(mk(1, 32'h9999_0009, 0, 0, 1, 32'h300, 0, 32'h84, 0, 1, 0, 32'h1234_0007, 32'h84, 6));

      for (int i = 0; i < vt.size(); i++) begin
         drive(vt[i].ih, vt[i].ld, vt[i].st, vt[i].dw, vt[i].rd, vt[i].rp, vt[i].hl);
         chk_all($sformatf("vec%0d", i), vt[i].e_addr, vt[i].e_ren, vt[i].e_halted, vt[i].e_valid,
                 vt[i].e_instr, vt[i].e_npc, vt[i].e_cnt);
      end

      do_reset("reset_halted");

      // PC wrap at the top of the address space.
      drive(0, 32'h0, 0, 0, 1, 32'hFFFF_FFFC, 0);
      chk_all("wrap_redir", 32'hFFFF_FFFC, 1, 0, 0, 32'h0, 32'h0, 32'h0);
      drive(1, 32'h5A5A_0001, 0, 0, 0, 32'h0, 0);
      chk_all("wrap_fetch", 32'h0, 1, 0, 1, 32'h5A5A_0001, 32'h0, 32'd1);

      // Reset while a stashed word is pending must drop it.
      drive(1, 32'h7777_0002, 1, 0, 0, 32'h0, 0);
      chk_all("held", 32'h0, 0, 0, 1, 32'h5A5A_0001, 32'h0, 32'd1);
      do_reset("reset_held");
      drive(0, 32'h0, 0, 0, 0, 32'h0, 0);
      chk_all("after_held_reset", PC_INIT, 1, 0, 0, 32'h0, 32'h0, 32'h0);

      model_reset();
      do_reset("reset_rand");
      for (int c = 0; c < 2000; c++) begin
         if (m_halted && ($urandom % 4 == 0)) begin
            do_reset($sformatf("rreset%0d", c));
            model_reset();
         end else begin
            ih = ($urandom % 4) != 0;
            ld = $urandom;
            st = ($urandom % 5) == 0;
            dw = ($urandom % 6) == 0;
            rd = ($urandom % 8) == 0;
            rp = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
            hl = ($urandom % 60) == 0;
            drive(ih, ld, st, dw, rd, rp, hl);
            model_step(ih, ld, st, dw, rd, rp, hl);
            chk_all($sformatf("rnd%0d", c), m_pc, !m_halted && (m_stash.size() == 0), m_halted,
                    m_valid, m_instr, m_npc, m_cnt);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
